// File: rtl/feature_bram_reader.sv
// feature_bram_reader: walks a rectangular tile in the feature buffer, issues one BRAM read per
// credit cycle and re-times the 1-cycle read latency into a valid/ready pixel stream.
// Optional build macro FEATURE_READER_ABORT_EN adds an 'abort' input that cancels a running tile.
module feature_bram_reader #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   cols,
    input  logic [ADDR_W:0]   rows,
    input  logic [ADDR_W-1:0] pitch,
`ifdef FEATURE_READER_ABORT_EN
    input  logic              abort,
`endif
    output logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] bram_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_eol,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

    localparam int unsigned EntW = DATA_W + 2;
    localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CntOne  = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] pitch_q, pitch_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   col_q, col_d, row_q, row_d;
    logic [ADDR_W:0]   cols_q, cols_d, rows_q, rows_d;
    logic              infl_q, infl_d;
    logic              tag_eol_q, tag_eol_d;
    logic              tag_last_q, tag_last_d;
    logic [EntW-1:0]   fifo_q [2];
    logic [EntW-1:0]   fifo_d [2];
    logic [1:0]        occ_q, occ_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              abort_req;
    logic [EntW-1:0]   arr_ent, head_ent;
    logic              pop, pop_fifo, push, issue, credit_ok;
    logic [2:0]        pend;
    logic [ADDR_W:0]   col_nxt, row_nxt;
    logic              last_col, last_row;

`ifdef FEATURE_READER_ABORT_EN
    assign abort_req = abort & busy_q;
`else
    assign abort_req = 1'b0;
`endif

    // Data arriving this cycle for the read issued last cycle, with its tags.
    assign arr_ent = {tag_last_q, tag_eol_q, bram_data};

    // Stream head: FIFO entry if any, otherwise fall through the arriving read so the first
    // pixel is visible one cycle after its address.
    always_comb begin
        head_ent = '0;
        if (occ_q != 2'd0) begin
            head_ent = fifo_q[0];
        end else if (infl_q) begin
            head_ent = arr_ent;
        end
    end

    assign m_valid   = (occ_q != 2'd0) | infl_q;
    assign m_data    = head_ent[DATA_W-1:0];
    assign m_eol     = head_ent[DATA_W];
    assign m_last    = head_ent[DATA_W+1];
    assign read_addr = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

    assign pop      = m_valid & m_ready;
    assign pop_fifo = pop & (occ_q != 2'd0);
    // An arriving read bypasses the FIFO only when it is the head and is taken right away.
    assign push     = infl_q & ~(pop & (occ_q == 2'd0));

    // Credit: buffered plus in-flight reads, minus the beat leaving now, must stay below 2.
    assign pend      = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    assign credit_ok = pend < 3'd2;
    assign issue     = (state_q == StRun) & credit_ok & ~abort_req;

    assign col_nxt  = col_q + CntOne;
    assign row_nxt  = row_q + CntOne;
    assign last_col = (col_nxt == cols_q);
    assign last_row = (row_nxt == rows_q);

    // Two-entry output FIFO: shift on pop, append arriving read behind what remains.
    always_comb begin
        fifo_d = fifo_q;
        occ_d  = occ_q;
        if (pop_fifo) begin
            fifo_d[0] = fifo_q[1];
            occ_d     = occ_q - 2'd1;
        end
        if (push) begin
            if (occ_d == 2'd0) begin
                fifo_d[0] = arr_ent;
            end else begin
                fifo_d[1] = arr_ent;
            end
            occ_d = occ_d + 2'd1;
        end
        if (abort_req) begin
            occ_d = 2'd0;
        end
    end

    // Command sequencing, address walk and tag pipe.
    always_comb begin
        state_d    = state_q;
        row_base_d = row_base_q;
        pitch_d    = pitch_q;
        addr_d     = addr_q;
        col_d      = col_q;
        row_d      = row_q;
        cols_d     = cols_q;
        rows_d     = rows_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        infl_d     = issue;
        tag_eol_d  = issue & last_col;
        tag_last_d = issue & last_col & last_row;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    row_base_d = base_addr;
                    addr_d     = base_addr;
                    pitch_d    = pitch;
                    cols_d     = cols;
                    rows_d     = rows;
                    col_d      = '0;
                    row_d      = '0;
                    busy_d     = 1'b1;
                    if (cols == '0 || rows == '0) begin
                        state_d = StFin;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (issue) begin
                    if (last_col) begin
                        row_base_d = row_base_q + pitch_q;
                        addr_d     = row_base_q + pitch_q;
                        col_d      = '0;
                        row_d      = row_nxt;
                        if (last_row) begin
                            state_d = StDrain;
                        end
                    end else begin
                        addr_d = addr_q + AddrOne;
                        col_d  = col_nxt;
                    end
                end
            end
            StDrain: begin
                // Nothing is issued here, so an empty FIFO next cycle means the last beat left.
                if (occ_d == 2'd0) begin
                    state_d = StFin;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            StFin: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        if (abort_req) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            infl_d  = 1'b0;
        end
    end

    // State registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            row_base_q <= '0;
            pitch_q    <= '0;
            addr_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            cols_q     <= '0;
            rows_q     <= '0;
            infl_q     <= 1'b0;
            tag_eol_q  <= 1'b0;
            tag_last_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            occ_q      <= 2'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_base_q <= row_base_d;
            pitch_q    <= pitch_d;
            addr_q     <= addr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            cols_q     <= cols_d;
            rows_q     <= rows_d;
            infl_q     <= infl_d;
            tag_eol_q  <= tag_eol_d;
            tag_last_q <= tag_last_d;
            fifo_q[0]  <= fifo_d[0];
            fifo_q[1]  <= fifo_d[1];
            occ_q      <= occ_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: doc/feature_bram_reader.md
# feature_bram_reader

Read-side engine for the feature map buffer. It takes a rectangular tile command (base, columns, rows, row pitch) and generates the sequential BRAM read addresses. It absorbs the buffer's fixed 1-cycle read latency and presents the pixels as a valid/ready stream with full backpressure support. It sits between the feature buffer's read port and downstream consumers (conv window builder, output packer).

## Interface
- `ADDR_W`, 12, BRAM address width.
- `DATA_W`, 8, pixel width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset. The single clock is `clk`; reset polarity and asynchronous behaviour are fixed.
- `start`  in  1  command strobe. Sampled only in IDLE.
- `base_addr`  in  ADDR_W  address of the tile's first pixel.
- `cols`  in  ADDR_W+1  pixels per row, 0..4096.
- `rows`  in  ADDR_W+1  rows per tile, 0..4096.
- `pitch`  in  ADDR_W  address step between row starts.
- `read_addr`  out  ADDR_W  to the BRAM read address.
- `bram_data`  in  DATA_W  from the BRAM data output. Valid 1 cycle after `read_addr`.
- `m_data`  out  DATA_W  stream pixel.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `m_eol`  out  1  qualifies the last pixel of a row.
- `m_last`  out  1  qualifies the last pixel of the tile.
- `busy`  out  1  high from the cycle after an accepted start until done.
- `done`  out  1  one-cycle pulse at command completion.

## Operation
- States:
  - IDLE: `start`=1 latches all command fields. If `cols`=0 or `rows`=0, go to FIN; otherwise go to RUN.
  - RUN: issue one read per credit cycle. After the final read, go to DRAIN.
  - DRAIN: wait until inflight=0 and the FIFO is empty, then go to FIN.
  - FIN: pulse `done`, return to IDLE.
- Address generation:
  - `read_addr` = `row_base` + `col`.
  - `row_base` starts at `base_addr` and advances by `pitch` at each row end.
  - All address sums are modulo 2^ADDR_W (wrap-around). There is no bounds error.
- Read-latency handling:
  - A read issued in cycle t is captured from `bram_data` in cycle t+1 into a 2-entry output FIFO.
  - The `eol` and `last` tags travel with the read in a 1-cycle tag pipe.
- Credit rule: issue in cycle t only if (FIFO occupancy + inflight − pop_t) < 2, where pop_t = `m_valid`&`m_ready`. This guarantees no overflow and no dropped BRAM data.
- Stream rules:
  - `m_data`, `m_eol` and `m_last` are held stable while `m_valid`=1 and `m_ready`=0.
  - `m_valid` is never withdrawn without a handshake.
- `start` is ignored while `busy`=1.
- Consistency rule: the tile must not be written during a read; the reader does not arbitrate.
- Reset: asynchronous, at any time, including mid-tile.
  - Returns to IDLE and flushes the FIFO and inflight state.
  - Reset values: `read_addr`=0, `m_data`=0, `m_valid`=0, `m_eol`=0, `m_last`=0, `busy`=0, `done`=0.

## Timing
- `start` sampled in cycle 0:
  - `busy`=1 in cycle 1, and the first `read_addr` is driven in cycle 1.
  - `m_valid`=1 in cycle 2.
- With `m_ready` held high, throughput is 1 pixel per cycle. Address N is issued in cycle 1+N; beat N is accepted in cycle 2+N.
- `done` pulses the cycle after the `m_last` handshake. `busy` falls in the same cycle as `done`.
- An empty tile gives `busy`=1 in cycle 1 and `done`=1 in cycle 1. No beats are produced.
- Backpressure: at most 2 pixels are buffered. Issue resumes in the cycle `m_ready` returns high.

## Configuration
- `FEATURE_READER_ABORT_EN`
  - Defined: adds input port `abort` (1 bit). If `abort`=1 while `busy`=1, the next cycle:
    - flushes the FIFO and tag pipe;
    - deasserts `m_valid`;
    - returns to IDLE with `busy`=0 and no `done` pulse.
  - `abort` in IDLE has no effect.
  - Undefined: no `abort` port; commands always run to completion.

## Test plan
- Basic tile, `m_ready` held high:
  - Stimulus: `base_addr`=0x010, `cols`=3, `rows`=2, `pitch`=0x040.
  - `read_addr` sequence 0x010, 0x011, 0x012, 0x050, 0x051, 0x052.
  - 6 consecutive beats with data equal to the preloaded memory contents.
  - `m_eol` on beats 3 and 6; `m_last` on beat 6; `done` one cycle later.
- Backpressure:
  - Stimulus: 4x4 tile with a pseudo-random `m_ready` pattern (~50%).
  - The output equals the reference order exactly: no loss, no duplication.
  - Data is held stable while stalled; `read_addr` never issues with credits exhausted.
- Wrap-around:
  - Stimulus: `base_addr`=0xFFE, `cols`=4, `rows`=1.
  - Addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Empty command: `rows`=0 → `done` in cycle 1, `m_valid` stays 0. A `start` issued while busy is ignored.
- Reset mid-tile: assert `reset`=0 after beat 2 of an 8-pixel tile.
  - All outputs take their reset values immediately.
  - A new tile after reset streams correctly from its own base.
- Abort (macro defined): `abort` pulse after beat 3 of a 16-pixel tile.
  - `m_valid`=0 and `busy`=0 the next cycle; no `done`.
  - The following command runs correctly.
